pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the ARM core, the generalised successor of the fixed decode/execute latch. It carries one control field and one data field per beat between any two pipeline stages, with a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and a flush statistics counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, each with its own widths.

---
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a
// valid/ready handshake, stall back-pressure, synchronous flush (bubble
// insertion) and a saturating flush statistics counter.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   -> 2-entry skid queue; in_ready decoded from registered occupancy only
//   undefined -> 1-entry latch; in_ready = empty | out_ready (combinational)
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               squash all held entries and the incoming beat
//   in_valid/in_ready   upstream handshake
//   in_ctrl/in_data     upstream control / data fields
//   out_valid/out_ready downstream handshake for the head entry
//   out_ctrl            head control field, 0 when out_valid=0
//   out_data            head data field, holds last value when empty
//   occupancy           number of held entries
//   flush_cnt           saturating count of effective flushes
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic              push;
    logic              pop;
    logic [1:0]        occ_d;
    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  cnt_d;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_d;

    // Ready depends only on registered state, breaking the inter-stage ready path.
    assign in_ready = (occupancy < 2'(DEPTH));
`else
    // Single entry can be replaced in the same cycle it is popped.
    assign in_ready = (occupancy < 2'(DEPTH)) | out_ready;
`endif

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next-state: head lives in out_ctrl/out_data, second entry in the skid regs.
    always_comb begin
        occ_d  = occupancy;
        ctrl_d = out_ctrl;
        data_d = out_data;
        cnt_d  = flush_cnt;
`ifdef PIPE_STAGE_SKID_EN
        skid_ctrl_d = skid_ctrl;
        skid_data_d = skid_data;
`endif
        if (flush) begin
            occ_d  = 2'd0;
            ctrl_d = '0;
            if (((occupancy != 2'd0) || in_valid) && (flush_cnt != {CNT_W{1'b1}})) begin
                cnt_d = flush_cnt + CNT_W'(1);
            end
        end else begin
            case ({push, pop})
                2'b10: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (occupancy != 2'd0) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        occ_d       = 2'd2;
                    end else begin
                        ctrl_d = in_ctrl;
                        data_d = in_data;
                        occ_d  = 2'd1;
                    end
`else
                    ctrl_d = in_ctrl;
                    data_d = in_data;
                    occ_d  = 2'd1;
`endif
                end
                2'b01: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (occupancy == 2'd2) begin
                        ctrl_d = skid_ctrl;
                        data_d = skid_data;
                        occ_d  = 2'd1;
                    end else begin
                        ctrl_d = '0;
                        occ_d  = 2'd0;
                    end
`else
                    ctrl_d = '0;
                    occ_d  = 2'd0;
`endif
                end
                // Push and pop together only happen with one entry held.
                2'b11: begin
                    ctrl_d = in_ctrl;
                    data_d = in_data;
                end
                default: begin
                end
            endcase
        end
        valid_d = (occ_d != 2'd0);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= 2'd0;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            flush_cnt <= '0;
        end else begin
            occupancy <= occ_d;
            out_valid <= valid_d;
            out_ctrl  <= ctrl_d;
            out_data  <= data_d;
            flush_cnt <= cnt_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            skid_ctrl <= skid_ctrl_d;
            skid_data <= skid_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Covers both build variants of PIPE_STAGE_SKID_EN; a second instance with
// CNT_W=2 shares all inputs to check flush counter saturation.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [7:0]        flush_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [1:0]        s_flush_cnt;

    int n_cmp;
    int n_err;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_cnt", 64'(flush_cnt), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;

        // Streaming: one beat per cycle, visible one edge later
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CTRL_W'(i);
            in_data  = 32'hA000_0000 | DATA_W'(i);
            tick();
            chk("strm_valid", 64'(out_valid), 64'd1);
            chk("strm_ctrl", 64'(out_ctrl), 64'(i));
            chk("strm_data", 64'(out_data), 64'(32'hA000_0000 | i));
            chk("strm_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_ctrl", 64'(out_ctrl), 64'd0);
        chk("drain_data_hold", 64'(out_data), 64'h0000_0000_A000_000A);
        chk("drain_occ", 64'(occupancy), 64'd0);

        // Empty with out_ready=1: nothing popped, still empty
        tick();
        chk("empty_occ", 64'(occupancy), 64'd0);

        // Stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h11;
        in_data   = 32'h1111;
        tick();
        chk("stall1_ctrl", 64'(out_ctrl), 64'h11);
        in_ctrl = 8'h22;
        in_data = 32'h2222;
`ifdef PIPE_STAGE_SKID_EN
        tick();
        chk("skid_occ2", 64'(occupancy), 64'd2);
        chk("skid_ready0", 64'(in_ready), 64'd0);
        chk("skid_hold", 64'(out_ctrl), 64'h11);
        in_valid  = 1'b0;
        tick();
        chk("skid_hold2", 64'(out_ctrl), 64'h11);
        out_ready = 1'b1;
        tick();
        chk("skid_pop1", 64'(out_ctrl), 64'h22);
        chk("skid_pop1_data", 64'(out_data), 64'h2222);
        chk("skid_ready1", 64'(in_ready), 64'd1);
        tick();
        chk("skid_pop2_occ", 64'(occupancy), 64'd0);
`else
        #1;
        chk("ns_ready0", 64'(in_ready), 64'd0);
        tick();
        chk("ns_hold", 64'(out_ctrl), 64'h11);
        chk("ns_occ", 64'(occupancy), 64'd1);
        out_ready = 1'b1;
        in_ctrl   = 8'h33;
        in_data   = 32'h3333;
        #1;
        chk("ns_ready_comb", 64'(in_ready), 64'd1);
        tick();
        chk("ns_pp_ctrl", 64'(out_ctrl), 64'h33);
        chk("ns_pp_occ", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("ns_drain_occ", 64'(occupancy), 64'd0);
`endif

        // Flush while full with in_valid=1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h44;
        in_data   = 32'hD1;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_ctrl = 8'h55;
        in_data = 32'hD2;
        tick();
        chk("full_occ", 64'(occupancy), 64'd2);
`else
        chk("full_occ", 64'(occupancy), 64'd1);
`endif
        flush   = 1'b1;
        in_ctrl = 8'h66;
        in_data = 32'hD3;
        tick();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_data_hold", 64'(out_data), 64'hD1);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_cnt1", 64'(flush_cnt), 64'd1);

        // Flush while empty with no beat: not counted
        in_valid = 1'b0;
        tick();
        chk("fl_idle_cnt", 64'(flush_cnt), 64'd1);

        // Flush while empty with a beat: counted, beat dropped
        in_valid = 1'b1;
        in_ctrl  = 8'h99;
        tick();
        chk("fl_beat_cnt", 64'(flush_cnt), 64'd2);
        chk("fl_beat_occ", 64'(occupancy), 64'd0);
        chk("sat_cnt2", 64'(s_flush_cnt), 64'd2);

        // Flush overrides downstream accept
        flush     = 1'b0;
        in_ctrl   = 8'h88;
        out_ready = 1'b1;
        tick();
        chk("pre_fl_ctrl", 64'(out_ctrl), 64'h88);
        flush    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("fl_pop_occ", 64'(occupancy), 64'd0);
        chk("fl_pop_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_pop_cnt", 64'(flush_cnt), 64'd3);
        chk("sat_cnt3", 64'(s_flush_cnt), 64'd3);

        // Two more effective flushes: wide counter 5, narrow stays 3
        in_valid = 1'b1;
        tick();
        tick();
        chk("fl_cnt5", 64'(flush_cnt), 64'd5);
        chk("sat_hold", 64'(s_flush_cnt), 64'd3);
        flush = 1'b0;

        // Asynchronous reset between edges mid-stream
        for (int i = 0; i < 3; i++) begin
            in_ctrl = CTRL_W'(8'hC0 + i);
            in_data = DATA_W'(32'hC0 + i);
            tick();
        end
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ctrl", 64'(out_ctrl), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_cnt", 64'(flush_cnt), 64'd0);
        chk("arst_sat_cnt", 64'(s_flush_cnt), 64'd0);
        tick();
        chk("arst_hold_occ", 64'(occupancy), 64'd0);
        #3;
        rst     = 1'b1;
        in_ctrl = 8'h77;
        in_data = 32'h7777;
        tick();
        chk("resume_valid", 64'(out_valid), 64'd1);
        chk("resume_ctrl", 64'(out_ctrl), 64'h77);
        chk("resume_data", 64'(out_data), 64'h7777);

        in_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
